// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl
// Clocked session sequencer placed in front of the combinational account/PIN
// authenticator. It latches the card number, runs FIND, accepts a PIN, runs
// AUTHENTICATE, counts failed PIN tries, locks accounts out and issues deAuth
// pulses whenever an open or half-open session is torn down.
//
// Optional build macro: SESSION_TIMEOUT_EN
//   defined   -> an idle counter in WAIT_PIN/ACTIVE forces a logout after
//                TIMEOUT_CYCLES idle cycles
//   undefined -> sessions end only on logout, lockout or rst
module atm_session_ctrl #(
   parameter int SETTLE_CYCLES  = 2,
   parameter int MAX_TRIES      = 3,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        card_valid,
   input  logic [15:0] card_acc,
   input  logic        pin_valid,
   input  logic [15:0] pin_in,
   input  logic        logout,
   input  logic        auth_ok,
   input  logic [3:0]  auth_idx,
   output logic [15:0] auth_acc,
   output logic [15:0] auth_pin,
   output logic        auth_action,
   output logic        auth_deauth,
   output logic        session_active,
   output logic [3:0]  session_index,
   output logic        card_rejected,
   output logic        pin_rejected,
   output logic        locked_out,
   output logic [2:0]  tries_left
);

   localparam int CNT_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int NUM_ACCOUNTS = 10;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FIND     = 3'd1,
      ST_WAIT_PIN = 3'd2,
      ST_CHECK    = 3'd3,
      ST_ACTIVE   = 3'd4
   } state_t;

   // Lock bit of an account index; indices outside the table are never locked
   function automatic logic lock_lookup(input logic [NUM_ACCOUNTS-1:0] map,
                                        input logic [3:0] idx);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
         if (idx == 4'(i)) begin
            hit = map[i];
         end
      end
      return hit;
   endfunction

   // Lock bitmap with the bit of one account index set
   function automatic logic [NUM_ACCOUNTS-1:0] lock_set(input logic [NUM_ACCOUNTS-1:0] map,
                                                        input logic [3:0] idx);
      logic [NUM_ACCOUNTS-1:0] res;
      res = map;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
         if (idx == 4'(i)) begin
            res[i] = 1'b1;
         end
      end
      return res;
   endfunction

   state_t                  state_r, state_s;
   logic [CNT_W-1:0]        cnt_r, cnt_s;
   logic [3:0]              idx_r, idx_s;
   logic [NUM_ACCOUNTS-1:0] lock_r, lock_s;
   logic [15:0]             auth_acc_s, auth_pin_s;
   logic                    auth_action_s, auth_deauth_s;
   logic                    session_active_s;
   logic [3:0]              session_index_s;
   logic                    card_rejected_s, pin_rejected_s, locked_out_s;
   logic [2:0]              tries_left_s;
   logic                    settle_done_s;
   logic                    timeout_s;
   logic                    end_req_s;

   // The authenticator result is trusted only after SETTLE_CYCLES stable cycles
   assign settle_done_s = (cnt_r == CNT_W'(SETTLE_CYCLES - 1));

   // A timeout ends a waiting session exactly like a user logout
   assign end_req_s = logout | timeout_s;

`ifdef SESSION_TIMEOUT_EN
   logic [31:0] idle_cnt_r, idle_cnt_s;

   // Timeout fires when the idle counter reaches its limit in a waiting state
   always_comb begin
      timeout_s = 1'b0;
      if (((state_r == ST_WAIT_PIN) || (state_r == ST_ACTIVE)) &&
          (idle_cnt_r == 32'(TIMEOUT_CYCLES - 1))) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
   end

   // Idle counter restarts on any state change or keypad PIN entry
   always_comb begin
      idle_cnt_s = 32'd0;
      if ((state_s != state_r) || pin_valid) begin
         idle_cnt_s = 32'd0;
      end else if ((state_r == ST_WAIT_PIN) || (state_r == ST_ACTIVE)) begin
         idle_cnt_s = idle_cnt_r + 32'd1;
      end else begin
         idle_cnt_s = 32'd0;
      end
   end

   // Idle counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_r <= 32'd0;
      end else begin
         idle_cnt_r <= idle_cnt_s;
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state and next-output decode of the session sequencer
   always_comb begin
      state_s          = state_r;
      cnt_s            = cnt_r;
      idx_s            = idx_r;
      lock_s           = lock_r;
      auth_acc_s       = auth_acc;
      auth_pin_s       = auth_pin;
      auth_action_s    = auth_action;
      session_active_s = session_active;
      session_index_s  = session_index;
      tries_left_s     = tries_left;
      auth_deauth_s    = 1'b0;
      card_rejected_s  = 1'b0;
      pin_rejected_s   = 1'b0;
      locked_out_s     = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (card_valid) begin
               state_s       = ST_FIND;
               auth_acc_s    = card_acc;
               auth_action_s = 1'b0;
               cnt_s         = '0;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_FIND: begin
            if (logout) begin
               state_s       = ST_IDLE;
               auth_deauth_s = 1'b1;
            end else if (settle_done_s) begin
               if (!auth_ok) begin
                  card_rejected_s = 1'b1;
                  state_s         = ST_IDLE;
               end else if (lock_lookup(lock_r, auth_idx)) begin
                  card_rejected_s = 1'b1;
                  locked_out_s    = 1'b1;
                  state_s         = ST_IDLE;
               end else begin
                  idx_s        = auth_idx;
                  tries_left_s = 3'(MAX_TRIES);
                  state_s      = ST_WAIT_PIN;
               end
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end

         ST_WAIT_PIN: begin
            if (end_req_s) begin
               state_s       = ST_IDLE;
               auth_deauth_s = 1'b1;
            end else if (pin_valid) begin
               state_s       = ST_CHECK;
               auth_pin_s    = pin_in;
               auth_action_s = 1'b1;
               cnt_s         = '0;
            end else begin
               state_s = ST_WAIT_PIN;
            end
         end

         ST_CHECK: begin
            if (logout) begin
               state_s       = ST_IDLE;
               auth_deauth_s = 1'b1;
            end else if (settle_done_s) begin
               if (auth_ok && (auth_idx == idx_r)) begin
                  session_active_s = 1'b1;
                  session_index_s  = idx_r;
                  state_s          = ST_ACTIVE;
               end else if (tries_left <= 3'd1) begin
                  tries_left_s  = 3'd0;
                  lock_s        = lock_set(lock_r, idx_r);
                  locked_out_s  = 1'b1;
                  auth_deauth_s = 1'b1;
                  state_s       = ST_IDLE;
               end else begin
                  tries_left_s   = tries_left - 3'd1;
                  pin_rejected_s = 1'b1;
                  state_s        = ST_WAIT_PIN;
               end
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end

         ST_ACTIVE: begin
            if (end_req_s) begin
               auth_deauth_s    = 1'b1;
               session_active_s = 1'b0;
               session_index_s  = 4'd0;
               state_s          = ST_IDLE;
            end else begin
               state_s = ST_ACTIVE;
            end
         end

         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // Leaving a session never leaves the account or PIN on the bus
      if ((state_s == ST_IDLE) && (state_r != ST_IDLE)) begin
         auth_acc_s    = 16'd0;
         auth_pin_s    = 16'd0;
         auth_action_s = 1'b0;
      end else begin
         auth_action_s = auth_action_s;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         cnt_r          <= '0;
         idx_r          <= 4'd0;
         lock_r         <= '0;
         auth_acc       <= 16'd0;
         auth_pin       <= 16'd0;
         auth_action    <= 1'b0;
         auth_deauth    <= 1'b0;
         session_active <= 1'b0;
         session_index  <= 4'd0;
         card_rejected  <= 1'b0;
         pin_rejected   <= 1'b0;
         locked_out     <= 1'b0;
         tries_left     <= 3'(MAX_TRIES);
      end else begin
         state_r        <= state_s;
         cnt_r          <= cnt_s;
         idx_r          <= idx_s;
         lock_r         <= lock_s;
         auth_acc       <= auth_acc_s;
         auth_pin       <= auth_pin_s;
         auth_action    <= auth_action_s;
         auth_deauth    <= auth_deauth_s;
         session_active <= session_active_s;
         session_index  <= session_index_s;
         card_rejected  <= card_rejected_s;
         pin_rejected   <= pin_rejected_s;
         locked_out     <= locked_out_s;
         tries_left     <= tries_left_s;
      end
   end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Testbench for atm_session_ctrl: behavioural authenticator plus a
// session-level reference model (account table, lock flags, try count).
module tb_atm_session_ctrl;

   localparam int SETTLE = 2;
   localparam int TRIES  = 3;
   localparam int TMO    = 20;

   logic        clk = 1'b0;
   logic        rst, card_valid, pin_valid, logout;
   logic [15:0] card_acc, pin_in;
   logic        auth_ok;
   logic [3:0]  auth_idx;
   logic [15:0] auth_acc, auth_pin;
   logic        auth_action, auth_deauth, session_active;
   logic [3:0]  session_index;
   logic        card_rejected, pin_rejected, locked_out;
   logic [2:0]  tries_left;

   int checks = 0;
   int fails  = 0;

   logic [15:0] acc_tab [10] = '{16'd1000, 16'd2175, 16'd2429, 16'd2749, 16'd2816,
                                 16'd3001, 16'd3112, 16'd4096, 16'd5555, 16'd6060};
   logic [15:0] pin_tab [10] = '{16'd7, 16'd1, 16'd2, 16'd3, 16'd4,
                                 16'd11, 16'd12, 16'd13, 16'd14, 16'd15};
   bit lock_m [10];

   atm_session_ctrl #(
      .SETTLE_CYCLES (SETTLE),
      .MAX_TRIES     (TRIES),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .card_valid    (card_valid),
      .card_acc      (card_acc),
      .pin_valid     (pin_valid),
      .pin_in        (pin_in),
      .logout        (logout),
      .auth_ok       (auth_ok),
      .auth_idx      (auth_idx),
      .auth_acc      (auth_acc),
      .auth_pin      (auth_pin),
      .auth_action   (auth_action),
      .auth_deauth   (auth_deauth),
      .session_active(session_active),
      .session_index (session_index),
      .card_rejected (card_rejected),
      .pin_rejected  (pin_rejected),
      .locked_out    (locked_out),
      .tries_left    (tries_left)
   );

   always #5 clk = ~clk;

   // Combinational authenticator: FIND matches account, AUTHENTICATE also needs PIN
   always_comb begin
      auth_ok  = 1'b0;
      auth_idx = 4'd0;
      for (int j = 0; j < 10; j++) begin
         if ((auth_acc == acc_tab[j]) && (!auth_action || (auth_pin == pin_tab[j]))) begin
            auth_ok  = 1'b1;
            auth_idx = 4'(j);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic int find_idx(input logic [15:0] acc);
      int r;
      r = -1;
      for (int j = 0; j < 10; j++) if (acc_tab[j] == acc) r = j;
      return r;
   endfunction

   task automatic drive_card(input logic [15:0] acc);
      card_valid = 1'b1; card_acc = acc;
      cyc();
      card_valid = 1'b0; card_acc = 16'($urandom);
   endtask

   task automatic drive_pin(input logic [15:0] p);
      pin_valid = 1'b1; pin_in = p;
      cyc();
      pin_valid = 1'b0; pin_in = 16'($urandom);
   endtask

   // One full session checked against the model; always ends back in IDLE
   task automatic run_session(input logic [15:0] acc, input logic [15:0] p0, input logic [15:0] p1,
                              input logic [15:0] p2, input int npins, input string tag);
      logic [15:0] pins [3];
      int i, tr;
      bit ok, exp_c, exp_l;
      logic [2:0] exp_t;
      pins = '{p0, p1, p2};
      i = find_idx(acc);
      drive_card(acc);
      checks++;
      if ({auth_acc, auth_pin, auth_action} !== {acc, 16'd0, 1'b0}) begin
         fails++;
         $display("FAIL %s find_bus: got %h/%h/%b expected %h/0000/0", tag, auth_acc, auth_pin, auth_action, acc);
      end
      repeat (SETTLE) cyc();
      exp_c = (i < 0) || lock_m[i];
      exp_l = (i >= 0) && lock_m[i];
      checks++;
      if ({card_rejected, locked_out, pin_rejected, auth_deauth} !== {exp_c, exp_l, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL %s card_result: got crej=%b lock=%b prej=%b deauth=%b expected crej=%b lock=%b prej=0 deauth=0",
                  tag, card_rejected, locked_out, pin_rejected, auth_deauth, exp_c, exp_l);
      end
      if (exp_c) begin
         cyc();
         checks++;
         if ({card_rejected, locked_out, auth_acc, auth_deauth} !== {1'b0, 1'b0, 16'd0, 1'b0}) begin
            fails++;
            $display("FAIL %s reject_after: got crej=%b lock=%b acc=%h deauth=%b expected 0/0/0000/0",
                     tag, card_rejected, locked_out, auth_acc, auth_deauth);
         end
         return;
      end
      checks++;
      if (tries_left !== 3'(TRIES)) begin
         fails++;
         $display("FAIL %s tries_init: got %0d expected %0d", tag, tries_left, TRIES);
      end
      tr = TRIES;
      ok = 1'b0;
      for (int k = 0; k < npins && !ok && tr > 0; k++) begin
         drive_pin(pins[k]);
         checks++;
         if ({auth_acc, auth_pin, auth_action} !== {acc, pins[k], 1'b1}) begin
            fails++;
            $display("FAIL %s check_bus: got %h/%h/%b expected %h/%h/1", tag, auth_acc, auth_pin, auth_action, acc, pins[k]);
         end
         repeat (SETTLE) cyc();
         if (pins[k] == pin_tab[i]) begin
            ok = 1'b1;
         end else begin
            tr--;
            if (tr == 0) lock_m[i] = 1'b1;
         end
         exp_t = 3'(tr);
         checks++;
         if ({session_active, session_index, pin_rejected, locked_out, card_rejected, auth_deauth, tries_left} !==
             {ok, ok ? 4'(i) : 4'd0, !ok && tr > 0, tr == 0, 1'b0, tr == 0, exp_t}) begin
            fails++;
            $display("FAIL %s pin_result: got act=%b idx=%0d prej=%b lock=%b crej=%b deauth=%b tries=%0d expected act=%b idx=%0d tries=%0d",
                     tag, session_active, session_index, pin_rejected, locked_out, card_rejected, auth_deauth,
                     tries_left, ok, ok ? i : 0, tr);
         end
      end
      if (tr == 0) begin
         cyc();
         checks++;
         if ({auth_acc, auth_pin, locked_out, auth_deauth} !== {16'd0, 16'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL %s lockout_after: got acc=%h pin=%h lock=%b deauth=%b expected 0/0/0/0",
                     tag, auth_acc, auth_pin, locked_out, auth_deauth);
         end
         return;
      end
      logout = 1'b1;
      cyc();
      logout = 1'b0;
      checks++;
      if ({auth_deauth, session_active, session_index, auth_acc, auth_pin, pin_rejected} !==
          {1'b1, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0}) begin
         fails++;
         $display("FAIL %s logout: got deauth=%b act=%b idx=%0d acc=%h pin=%h prej=%b expected 1/0/0/0000/0000/0",
                  tag, auth_deauth, session_active, session_index, auth_acc, auth_pin, pin_rejected);
      end
      cyc();
      checks++;
      if (auth_deauth !== 1'b0) begin
         fails++;
         $display("FAIL %s deauth_width: got %b expected 0", tag, auth_deauth);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      checks++;
      if ({auth_acc, auth_pin, auth_action, auth_deauth, session_active, session_index,
           card_rejected, pin_rejected, locked_out, tries_left} !==
          {16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'(TRIES)}) begin
         fails++;
         $display("FAIL reset_outputs: got acc=%h pin=%h act=%b tries=%0d expected all 0, tries=%0d",
                  auth_acc, auth_pin, session_active, tries_left, TRIES);
      end
      for (int j = 0; j < 10; j++) lock_m[j] = 1'b0;
   endtask

   task automatic test_directed();
      run_session(16'd2175, 16'd1, 16'd0, 16'd0, 1, "login_2175");
      run_session(16'd1234, 16'd0, 16'd0, 16'd0, 0, "unknown_1234");
      run_session(16'd2429, 16'd5, 16'd6, 16'd2, 3, "retry_2429");
   endtask

   task automatic test_lockout();
      run_session(16'd2429, 16'd0, 16'd0, 16'd0, 3, "lockout_2429");
      run_session(16'd2429, 16'd2, 16'd0, 16'd0, 1, "locked_2429");
      // Reset in the middle of a session: no deauth, lock map cleared
      drive_card(16'd2175);
      repeat (SETTLE) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++;
      if ({auth_deauth, auth_acc, session_active, tries_left} !== {1'b0, 16'd0, 1'b0, 3'(TRIES)}) begin
         fails++;
         $display("FAIL midreset: got deauth=%b acc=%h act=%b tries=%0d expected 0/0000/0/%0d",
                  auth_deauth, auth_acc, session_active, tries_left, TRIES);
      end
      for (int j = 0; j < 10; j++) lock_m[j] = 1'b0;
      run_session(16'd2429, 16'd2, 16'd0, 16'd0, 1, "unlocked_2429");
   endtask

   task automatic test_logout_abort();
      drive_card(16'd2749);
      repeat (SETTLE) cyc();
      drive_pin(16'd0);
      repeat (SETTLE - 1) cyc();
      logout = 1'b1;
      cyc();
      logout = 1'b0;
      checks++;
      if ({auth_deauth, pin_rejected, locked_out, tries_left, auth_acc, auth_pin} !==
          {1'b1, 1'b0, 1'b0, 3'(TRIES), 16'd0, 16'd0}) begin
         fails++;
         $display("FAIL abort_check: got deauth=%b prej=%b lock=%b tries=%0d acc=%h pin=%h expected 1/0/0/%0d/0/0",
                  auth_deauth, pin_rejected, locked_out, tries_left, auth_acc, auth_pin, TRIES);
      end
      cyc();
      run_session(16'd2749, 16'd3, 16'd0, 16'd0, 1, "after_abort_2749");
   endtask

   task automatic test_ignored_strobes();
      pin_valid = 1'b1; pin_in = 16'h1234;
      cyc();
      pin_valid = 1'b0;
      checks++;
      if ({auth_pin, auth_action, auth_acc} !== {16'd0, 1'b0, 16'd0}) begin
         fails++;
         $display("FAIL pin_in_idle: got pin=%h act=%b acc=%h expected 0/0/0", auth_pin, auth_action, auth_acc);
      end
      drive_card(16'd2816);
      repeat (SETTLE) cyc();
      drive_card(16'd1000);
      checks++;
      if ({auth_acc, card_rejected} !== {16'd2816, 1'b0}) begin
         fails++;
         $display("FAIL card_in_waitpin: got acc=%h crej=%b expected 2816(0b00)/0", auth_acc, card_rejected);
      end
      logout = 1'b1;
      cyc();
      logout = 1'b0;
      checks++;
      if (auth_deauth !== 1'b1) begin
         fails++;
         $display("FAIL waitpin_logout: got deauth=%b expected 1", auth_deauth);
      end
      cyc();
   endtask

   task automatic test_timeout();
      int seen;
      seen = 0;
      drive_card(16'd2816);
      repeat (SETTLE) cyc();
      for (int n = 1; n <= 2 * TMO; n++) begin
         cyc();
         if (auth_deauth && seen == 0) seen = n;
      end
`ifdef SESSION_TIMEOUT_EN
      checks++;
      if (seen != TMO) begin
         fails++;
         $display("FAIL timeout_cycle: got deauth at %0d expected %0d", seen, TMO);
      end
      checks++;
      if (auth_acc !== 16'd0) begin
         fails++;
         $display("FAIL timeout_idle: got acc=%h expected 0000", auth_acc);
      end
`else
      checks++;
      if (seen != 0) begin
         fails++;
         $display("FAIL no_timeout: got deauth at %0d expected none", seen);
      end
      drive_pin(16'd4);
      repeat (SETTLE) cyc();
      checks++;
      if ({session_active, session_index} !== {1'b1, 4'd4}) begin
         fails++;
         $display("FAIL still_waitpin: got act=%b idx=%0d expected 1/4", session_active, session_index);
      end
      logout = 1'b1;
      cyc();
      logout = 1'b0;
      cyc();
`endif
   endtask

   task automatic test_back_to_back();
      run_session(16'd3001, 16'd11, 16'd0, 16'd0, 1, "b2b_a");
      run_session(16'd3112, 16'd99, 16'd12, 16'd0, 2, "b2b_b");
   endtask

   task automatic test_random();
      logic [15:0] acc, good;
      logic [15:0] p [3];
      int i;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 9) < 2) acc = 16'h8000 | 16'($urandom);
         else acc = acc_tab[$urandom_range(0, 9)];
         i = find_idx(acc);
         good = (i >= 0) ? pin_tab[i] : 16'd0;
         for (int k = 0; k < 3; k++) begin
            if ($urandom_range(0, 2) == 0) p[k] = good;
            else p[k] = good + 16'($urandom_range(1, 50));
         end
         run_session(acc, p[0], p[1], p[2], $urandom_range(1, 3), "random");
      end
   endtask

   initial begin
      rst = 1'b1; card_valid = 1'b0; pin_valid = 1'b0; logout = 1'b0;
      card_acc = 16'd0; pin_in = 16'd0;
      test_reset();
      test_directed();
      test_lockout();
      test_logout_abort();
      test_ignored_strobes();
      test_timeout();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
